// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the registered ALU.
//   opc_e   - 4-bit opcode encoding (12..15 reserved)
//   state_e - sequencer states
//   flags_t - status flags {err, ovf, neg, carry, zero}
//   FLAG_*  - bit positions of each flag inside flags_t
// Optional feature macro used by the design: ALU_SEQ_MUL_EN.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OPC_OR    = 4'd0,
      OPC_AND   = 4'd1,
      OPC_XOR   = 4'd2,
      OPC_NOT   = 4'd3,
      OPC_ADD   = 4'd4,
      OPC_SUB   = 4'd5,
      OPC_INCA  = 4'd6,
      OPC_INCB  = 4'd7,
      OPC_SHL   = 4'd8,
      OPC_SHR   = 4'd9,
      OPC_ASR   = 4'd10,
      OPC_MUL   = 4'd11,
      OPC_RSV12 = 4'd12,
      OPC_RSV13 = 4'd13,
      OPC_RSV14 = 4'd14,
      OPC_RSV15 = 4'd15
   } opc_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

   typedef struct packed {
      logic err;
      logic ovf;
      logic neg;
      logic carry;
      logic zero;
   } flags_t;

   localparam int unsigned FLAG_ZERO  = 0;
   localparam int unsigned FLAG_CARRY = 1;
   localparam int unsigned FLAG_NEG   = 2;
   localparam int unsigned FLAG_OVF   = 3;
   localparam int unsigned FLAG_ERR   = 4;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add unsigned multiplier.
//   clk, rst_n (sync, active-low) - clock and reset
//   start                        - load operands a/b and begin
//   a, b                         - WIDTH-bit unsigned operands
//   done                         - product valid (held until next start)
//   product                      - 2*WIDTH-bit product
// Only compiled into alu_seq when ALU_SEQ_MUL_EN is defined.
module alu_seq_mul
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic               r_loaded;

   // Bit 0 of b is folded into the load so WIDTH-1 further edges finish the product.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_loaded <= 1'b0;
      end else if (start) begin
         r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
         r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
         r_mplier <= {1'b0, b[WIDTH-1:1]};
         r_cnt    <= CW'(WIDTH - 1);
         r_loaded <= 1'b1;
      end else if (r_cnt != '0) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - CW'(1);
      end
   end

   assign done    = r_loaded && (r_cnt == '0);
   assign product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready, opc[3:0], a, b - request side
//   out_valid/out_ready, s, flags[4:0] - result side, flags = {err, ovf, neg, carry, zero}
//   busy                              - multi-cycle multiply in progress
// Define ALU_SEQ_MUL_EN to enable the iterative multiplier (opcode 11); otherwise
// opcode 11 behaves as a reserved opcode and busy is tied low.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [4:0]       flags,
   output logic             busy
);

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_s, w_s_d;
   flags_t           r_flags, w_flags_d;
   logic             r_out_valid, w_out_valid_d;

   opc_e             w_opc;
   logic             w_accept;
   logic             w_is_mul;
   logic [WIDTH-1:0] w_res;
   flags_t           w_res_flags;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH:0]   w_shr;
   logic [WIDTH:0]   w_asr;
   logic [SHW-1:0]   w_sh;

   assign w_opc    = opc_e'(opc);
   assign in_ready = rst_n && (r_state == IDLE) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Shifts run one bit wider than the operand so the last bit shifted out lands
   // in the extra bit (and that bit stays 0 for a shift amount of 0).
   always_comb begin
      w_sh        = b[SHW-1:0];
      w_shl       = {1'b0, a} << w_sh;
      w_shr       = {a, 1'b0} >> w_sh;
      w_asr       = $signed({a, 1'b0}) >>> w_sh;
      w_sum       = '0;
      w_res       = '0;
      w_res_flags = '0;
      case (w_opc)
         OPC_OR:  w_res = a | b;
         OPC_AND: w_res = a & b;
         OPC_XOR: w_res = a ^ b;
         OPC_NOT: w_res = ~a;
         OPC_ADD: begin
            w_sum             = {1'b0, a} + {1'b0, b};
            w_res             = w_sum[WIDTH-1:0];
            w_res_flags.carry = w_sum[WIDTH];
            w_res_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
         end
         OPC_SUB: begin
            w_sum             = {1'b0, a} - {1'b0, b};
            w_res             = w_sum[WIDTH-1:0];
            w_res_flags.carry = w_sum[WIDTH];
            w_res_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
         end
         OPC_INCA: begin
            w_sum             = {1'b0, a} + (WIDTH+1)'(1);
            w_res             = w_sum[WIDTH-1:0];
            w_res_flags.carry = w_sum[WIDTH];
            w_res_flags.ovf   = !a[WIDTH-1] && w_res[WIDTH-1];
         end
         OPC_INCB: begin
            w_sum             = {1'b0, b} + (WIDTH+1)'(1);
            w_res             = w_sum[WIDTH-1:0];
            w_res_flags.carry = w_sum[WIDTH];
            w_res_flags.ovf   = !b[WIDTH-1] && w_res[WIDTH-1];
         end
         OPC_SHL: begin
            w_res             = w_shl[WIDTH-1:0];
            w_res_flags.carry = w_shl[WIDTH];
         end
         OPC_SHR: begin
            w_res             = w_shr[WIDTH:1];
            w_res_flags.carry = w_shr[0];
         end
         OPC_ASR: begin
            w_res             = w_asr[WIDTH:1];
            w_res_flags.carry = w_asr[0];
         end
         // MUL is produced by the multiplier; here it falls into the reserved path.
         default: w_res_flags.err = 1'b1;
      endcase
      if (!w_res_flags.err) begin
         w_res_flags.zero = (w_res == '0);
         w_res_flags.neg  = w_res[WIDTH-1];
      end
   end

`ifdef ALU_SEQ_MUL_EN
   logic               w_mul_start;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_mul_s;
   flags_t             w_mul_flags;

   assign w_is_mul    = (w_opc == OPC_MUL);
   assign w_mul_start = w_accept && w_is_mul;
   assign busy        = (r_state == MUL);

   alu_seq_mul #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (w_mul_start),
      .a      (a),
      .b      (b),
      .done   (w_mul_done),
      .product(w_prod)
   );

   always_comb begin
      w_mul_flags       = '0;
      w_mul_s           = w_prod[WIDTH-1:0];
      w_mul_flags.carry = |w_prod[2*WIDTH-1:WIDTH];
      w_mul_flags.zero  = (w_mul_s == '0);
      w_mul_flags.neg   = w_mul_s[WIDTH-1];
   end
`else
   assign w_is_mul = 1'b0;
   assign busy     = 1'b0;
`endif

   always_comb begin
      w_state_d     = r_state;
      w_s_d         = r_s;
      w_flags_d     = r_flags;
      w_out_valid_d = r_out_valid && !out_ready;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_is_mul) begin
                  w_state_d = MUL;
               end else begin
                  w_s_d         = w_res;
                  w_flags_d     = w_res_flags;
                  w_out_valid_d = 1'b1;
               end
            end
         end
         MUL: begin
`ifdef ALU_SEQ_MUL_EN
            // Finished product waits here if the previous result is still unconsumed.
            if (w_mul_done && (!r_out_valid || out_ready)) begin
               w_s_d         = w_mul_s;
               w_flags_d     = w_mul_flags;
               w_out_valid_d = 1'b1;
               w_state_d     = IDLE;
            end
`else
            w_state_d = IDLE;
`endif
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_s         <= '0;
         r_flags     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_s         <= w_s_d;
         r_flags     <= w_flags_d;
         r_out_valid <= w_out_valid_d;
      end
   end

   assign s         = r_s;
   assign flags     = r_flags;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8), scoreboard of expected
// {s, flags} pushed at request time and popped when the result is observed.
// Honours ALU_SEQ_MUL_EN for opcode 11 expectations.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   opc;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic [4:0]   flags;
   logic         busy;

   int total = 0;
   int bad   = 0;
   logic [W+4:0] exp_q[$];

   always #5 clk = ~clk;

   alu_seq #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .opc      (opc),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
      .flags    (flags),
      .busy     (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model on plain integers; returns {s, err, ovf, neg, carry, zero}.
   function automatic logic [W+4:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      int   ux   = int'(x);
      int   uy   = int'(y);
      int   full = 1 << W;
      int   half = 1 << (W - 1);
      int   sx   = (ux >= half) ? ux - full : ux;
      int   sy   = (uy >= half) ? uy - full : uy;
      int   sh   = uy % W;
      int   r    = 0;
      int   rs   = 0;
      logic c    = 1'b0;
      logic v    = 1'b0;
      logic e    = 1'b0;
      logic [W-1:0] rv;
      case (op)
         4'd0: r = ux | uy;
         4'd1: r = ux & uy;
         4'd2: r = ux ^ uy;
         4'd3: r = ~ux;
         4'd4: begin r = ux + uy; c = (r >= full); rs = sx + sy; v = (rs >= half) || (rs < -half); end
         4'd5: begin r = ux - uy; c = (ux < uy);  rs = sx - sy; v = (rs >= half) || (rs < -half); end
         4'd6: begin r = ux + 1;  c = (r >= full); rs = sx + 1;  v = (rs >= half); end
         4'd7: begin r = uy + 1;  c = (r >= full); rs = sy + 1;  v = (rs >= half); end
         4'd8: begin r = ux << sh; c = (sh != 0) && (((ux >> (W - sh)) & 1) == 1); end
         4'd9: begin r = ux >> sh; c = (sh != 0) && (((ux >> (sh - 1)) & 1) == 1); end
         4'd10: begin r = sx >>> sh; c = (sh != 0) && (((ux >> (sh - 1)) & 1) == 1); end
`ifdef ALU_SEQ_MUL_EN
         4'd11: begin r = ux * uy; c = ((r >> W) != 0); end
`endif
         default: e = 1'b1;
      endcase
      if (e) r = 0;
      rv = r[W-1:0];
      return {rv, e, v, (!e && rv[W-1]), c, (!e && rv == '0)};
   endfunction

   function automatic int mul_lat(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
      return (op == 4'd11) ? W : 0;
`else
      return 0;
`endif
   endfunction

   // One isolated transaction: wait for in_ready, issue, wait for the result, consume it.
   task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W+4:0] expv);
      int n = 0;
      int bc = 0;
      int lat = mul_lat(op);
      logic [W+4:0] e;
      while (!in_ready && n < 50) begin tick(); n++; end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL %s ready-timeout: in_ready=%b want 1", name, in_ready);
      end
      exp_q.push_back(expv);
      opc = op; a = x; b = y; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         if (busy === 1'b1) bc++;
         tick();
         n++;
      end
      total++;
      if (n != lat) begin
         bad++; $display("FAIL %s latency: got %0d want %0d (out_valid=%b)", name, n, lat, out_valid);
      end
      total++;
      if (bc != lat) begin
         bad++; $display("FAIL %s busy-cycles: got %0d want %0d", name, bc, lat);
      end
      e = exp_q.pop_front();
      total++;
      if (s !== e[W+4:5]) begin
         bad++; $display("FAIL %s s: got %h want %h", name, s, e[W+4:5]);
      end
      total++;
      if (flags !== e[4:0]) begin
         bad++; $display("FAIL %s flags: got %b want %b", name, flags, e[4:0]);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL %s drop-valid: out_valid=%b want 0", name, out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opc = '0; a = '0; b = '0;
      tick(); tick();
      total++;
      if (s !== '0 || flags !== '0) begin
         bad++; $display("FAIL reset s/flags: got %h/%b want 00/00000", s, flags);
      end
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset valid/busy: got %b/%b want 0/0", out_valid, busy);
      end
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL reset in_ready: got %b want 0", in_ready);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL release in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add_ovf();
      do_op("add_7f_01", 4'd4, 8'h7F, 8'h01, {8'h80, 5'b01100});
   endtask

   task automatic test_sub_asr();
      do_op("sub_03_05", 4'd5, 8'h03, 8'h05, {8'hFE, 5'b00110});
      do_op("asr_80_03", 4'd10, 8'h80, 8'h03, {8'hF0, 5'b00100});
   endtask

   task automatic test_ops_table();
      logic [W-1:0] xs[6] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h5A, 8'h01};
      logic [W-1:0] ys[6] = '{8'h08, 8'hFF, 8'h01, 8'h00, 8'h03, 8'h07};
      for (int op = 0; op < 16; op++) begin
         for (int k = 0; k < 2; k++) begin
            int i = (op + k * 3) % 6;
            do_op($sformatf("tbl_op%0d_%0d", op, k), op[3:0], xs[i], ys[i],
                  model(op[3:0], xs[i], ys[i]));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W+4:0] e;
      // Stall: first result held while out_ready is low, second request waits.
      out_ready = 1'b0;
      opc = 4'd4; a = 8'h10; b = 8'h20; in_valid = 1'b1;
      exp_q.push_back(model(4'd4, 8'h10, 8'h20));
      tick();
      opc = 4'd2; a = 8'hF0; b = 8'h3C;
      exp_q.push_back(model(4'd2, 8'hF0, 8'h3C));
      for (int k = 0; k < 3; k++) begin
         total++;
         if (out_valid !== 1'b1 || s !== exp_q[0][W+4:5] || flags !== exp_q[0][4:0]) begin
            bad++;
            $display("FAIL stall-hold%0d: v/s/f got %b/%h/%b want 1/%h/%b", k, out_valid, s,
                     flags, exp_q[0][W+4:5], exp_q[0][4:0]);
         end
         total++;
         if (in_ready !== 1'b0) begin
            bad++; $display("FAIL stall-ready%0d: in_ready=%b want 0", k, in_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL stall-release: in_ready=%b want 1", in_ready);
      end
      e = exp_q.pop_front();
      total++;
      if (s !== e[W+4:5] || flags !== e[4:0]) begin
         bad++; $display("FAIL stall-first: got %h/%b want %h/%b", s, flags, e[W+4:5], e[4:0]);
      end
      tick();
      in_valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || s !== e[W+4:5] || flags !== e[4:0]) begin
         bad++;
         $display("FAIL stall-second: v/s/f got %b/%h/%b want 1/%h/%b", out_valid, s, flags,
                  e[W+4:5], e[4:0]);
      end
      // Streaming at one op per cycle, consuming and accepting on the same edge.
      for (int i = 0; i < 6; i++) begin
         opc = 4'($urandom_range(0, 10)); a = 8'($urandom); b = 8'($urandom);
         in_valid = 1'b1;
         exp_q.push_back(model(opc, a, b));
         total++;
         if (in_ready !== 1'b1) begin
            bad++; $display("FAIL stream-ready%0d: in_ready=%b want 1", i, in_ready);
         end
         tick();
         e = exp_q.pop_front();
         total++;
         if (out_valid !== 1'b1 || s !== e[W+4:5] || flags !== e[4:0]) begin
            bad++;
            $display("FAIL stream%0d: v/s/f got %b/%h/%b want 1/%h/%b", i, out_valid, s, flags,
                     e[W+4:5], e[4:0]);
         end
      end
      in_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL stream-drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
      do_op("mul_12_10", 4'd11, 8'h12, 8'h10, {8'h20, 5'b00010});
      do_op("mul_ff_ff", 4'd11, 8'hFF, 8'hFF, {8'h01, 5'b00010});
      do_op("mul_03_05", 4'd11, 8'h03, 8'h05, {8'h0F, 5'b00000});
`else
      do_op("mul_12_10", 4'd11, 8'h12, 8'h10, {8'h00, 5'b10000});
`endif
   endtask

   task automatic test_reset_mid_op();
      // With the multiplier this resets mid-MUL; without it, with a pending output.
      out_ready = 1'b0;
      opc = 4'd11; a = 8'h12; b = 8'h10; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL midrst busy/valid: got %b/%b want 0/0", busy, out_valid);
      end
      total++;
      if (s !== '0 || flags !== '0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL midrst s/f/rdy: got %h/%b/%b want 00/00000/0", s, flags, in_ready);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL midrst release: in_ready=%b want 1", in_ready);
      end
      for (int k = 0; k < W + 2; k++) begin
         tick();
         total++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst stale%0d: valid/busy=%b/%b want 0/0", k, out_valid, busy);
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reserved();
      do_op("rsv_13", 4'd13, 8'hAA, 8'h55, {8'h00, 5'b10000});
      do_op("rsv_12", 4'd12, 8'h00, 8'h00, {8'h00, 5'b10000});
      do_op("rsv_15", 4'd15, 8'hFF, 8'h01, {8'h00, 5'b10000});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add_ovf();
      test_sub_asr();
      test_ops_table();
      test_back_to_back();
      test_mul();
      test_reset_mid_op();
      test_reserved();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
